// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory bus arbiter.
//   arbState_t : arbiter FSM states (IDLE / ADDR / DATA)
//   GNT_*      : one-bit grant IDs naming the master that owns the bus
//   SIZE_*     : encodings of the mem_size / dcache_mem_size fields
// Configuration macro: MEM_ARB_RR_EN (round-robin tie-break in mem_arb_grant).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arbState_t;

  localparam logic GNT_DCACHE = 1'b0;
  localparam logic GNT_ICACHE = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Combinational winner selection between the data-cache DMA path and the
// instruction-cache refill path.
// Ports:
//   i_dcacheReq  : data-side request
//   i_icacheReq  : instruction-side request
//   i_lastGrant  : master granted most recently (only with MEM_ARB_RR_EN)
//   o_grant      : winner ID (GNT_DCACHE / GNT_ICACHE)
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> on a tie the master that did not win last time wins
//   undefined -> on a tie the data cache always wins
// -----------------------------------------------------------------------------
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_dcacheReq,
  input  logic i_icacheReq,
`ifdef MEM_ARB_RR_EN
  input  logic i_lastGrant,
`endif
  output logic o_grant
);

  // A lone requester always wins. When nobody requests the output is a don't
  // care, so it defaults to the data cache. Only a genuine tie consults the
  // tie-break policy selected at build time.
  always_comb begin
    o_grant = GNT_DCACHE;
    if (i_icacheReq && !i_dcacheReq) begin
      o_grant = GNT_ICACHE;
    end else if (i_icacheReq && i_dcacheReq) begin
`ifdef MEM_ARB_RR_EN
      o_grant = (i_lastGrant == GNT_DCACHE) ? GNT_ICACHE : GNT_DCACHE;
`else
      o_grant = GNT_DCACHE;
`endif
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single uncached memory port between the icache refill path and
// the dcache DMA path, with at most one transaction in flight.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   icache_mem_req/addr             : instruction-side read request
//   mem_icache_addrOK/dataOK/rdata  : instruction-side responses
//   dcache_mem_req/wr/addr/wdata/size/wstrb : data-side request
//   mem_dcache_addrOK/dataOK/rdata  : data-side responses
//   mem_req/wr/addr/wdata/size/wstrb: registered request to the memory bridge
//   mem_addrOK/dataOK/rdata         : responses from the memory bridge
// Configuration macro: MEM_ARB_RR_EN (round-robin tie-break, adds last_grant).
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int OFFSET_WIDTH = 2,
  localparam int LINE_W       = 32 * (2 << OFFSET_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_mem_req,
  input  logic [31:0]       icache_mem_addr,
  output logic              mem_icache_addrOK,
  output logic              mem_icache_dataOK,
  output logic [LINE_W-1:0] mem_icache_rdata,

  input  logic              dcache_mem_req,
  input  logic              dcache_mem_wr,
  input  logic [31:0]       dcache_mem_addr,
  input  logic [31:0]       dcache_mem_wdata,
  input  logic [1:0]        dcache_mem_size,
  input  logic [3:0]        dcache_mem_wstrb,
  output logic              mem_dcache_addrOK,
  output logic              mem_dcache_dataOK,
  output logic [LINE_W-1:0] mem_dcache_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_addrOK,
  input  logic              mem_dataOK,
  input  logic [LINE_W-1:0] mem_rdata
);

  arbState_t   r_state;
  arbState_t   w_nextState;
  logic        w_load;
  logic        w_grant;
  logic        r_grant;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
`ifdef MEM_ARB_RR_EN
  logic        r_lastGrant;
`endif

  // Winner selection lives in its own block so the tie-break policy is
  // swapped in one place.
  mem_arb_grant u_grant (
    .i_dcacheReq (dcache_mem_req),
    .i_icacheReq (icache_mem_req),
`ifdef MEM_ARB_RR_EN
    .i_lastGrant (r_lastGrant),
`endif
    .o_grant     (w_grant)
  );

  // State register plus the latched copy of the winning request. The bridge
  // sees only these registers, so a master may change its inputs freely once
  // it has seen its addrOK. The icache is read-only and always fetches whole
  // words, so its write fields are filled with fixed values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= GNT_DCACHE;
      r_wr        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_size      <= SIZE_B;
      r_wstrb     <= 4'd0;
`ifdef MEM_ARB_RR_EN
      r_lastGrant <= GNT_ICACHE;
`endif
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_grant <= w_grant;
`ifdef MEM_ARB_RR_EN
        r_lastGrant <= w_grant;
`endif
        if (w_grant == GNT_ICACHE) begin
          r_wr    <= 1'b0;
          r_addr  <= icache_mem_addr;
          r_wdata <= 32'd0;
          r_size  <= SIZE_W;
          r_wstrb <= 4'b1111;
        end else begin
          r_wr    <= dcache_mem_wr;
          r_addr  <= dcache_mem_addr;
          r_wdata <= dcache_mem_wdata;
          r_size  <= dcache_mem_size;
          r_wstrb <= dcache_mem_wstrb;
        end
      end
    end
  end

  // Next-state and handshake steering. Bridge responses are passed straight
  // through to the granted master, but only in the state where that response
  // is expected; a stray addrOK in DATA or dataOK in ADDR is dropped. Writes
  // have no data phase and finish on addrOK.
  always_comb begin
    w_nextState       = r_state;
    w_load            = 1'b0;
    mem_req           = 1'b0;
    mem_icache_addrOK = 1'b0;
    mem_icache_dataOK = 1'b0;
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;
    case (r_state)
      IDLE: begin
        if (icache_mem_req || dcache_mem_req) begin
          w_load      = 1'b1;
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addrOK) begin
          mem_icache_addrOK = (r_grant == GNT_ICACHE);
          mem_dcache_addrOK = (r_grant == GNT_DCACHE);
          w_nextState       = r_wr ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mem_dataOK) begin
          mem_icache_dataOK = (r_grant == GNT_ICACHE);
          mem_dcache_dataOK = (r_grant == GNT_DCACHE);
          w_nextState       = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The memory side is driven purely from the latched request; read data is
  // broadcast and qualified by the per-master dataOK.
  assign mem_wr           = r_wr;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_size         = r_size;
  assign mem_wstrb        = r_wstrb;
  assign mem_icache_rdata = mem_rdata;
  assign mem_dcache_rdata = mem_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single uncached memory port between the instruction cache refill path and the data-cache DMA path. It sits between the L1 caches and the memory bridge. It serialises at most one outstanding transaction, registers the winning request onto the memory side, and steers addrOK, dataOK and read data back to the granted master only.

## Interface
- OFFSET_WIDTH, 2, line = 32*(2<<OFFSET_WIDTH) bits (256 at default)
- LINE_W, 32*(2<<OFFSET_WIDTH), read-data width, derived, not overridable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- icache_mem_req  in  1  instruction-side request, read only
- icache_mem_addr  in  32  instruction-side address
- mem_icache_addrOK  out  1  instruction-side address accepted
- mem_icache_dataOK  out  1  instruction-side data valid
- mem_icache_rdata  out  LINE_W  instruction-side line
- dcache_mem_req, dcache_mem_wr  in  1 each  data-side request; 0 read, 1 write
- dcache_mem_addr, dcache_mem_wdata  in  32 each
- dcache_mem_size  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B
- dcache_mem_wstrb  in  4  byte enables
- mem_dcache_addrOK, mem_dcache_dataOK  out  1 each
- mem_dcache_rdata  out  LINE_W
- mem_req, mem_wr  out  1 each  to bridge
- mem_addr, mem_wdata  out  32 each
- mem_size  out  2
- mem_wstrb  out  4
- mem_addrOK, mem_dataOK  in  1 each  from bridge
- mem_rdata  in  LINE_W

## Operation
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any request is high, the arbiter picks the winner and latches its fields into registers.
  - For the icache winner, the latched values are wr=0, size=2, wstrb=4'b1111, wdata=0.
  - It records the grant ID and goes to ADDR.
- ADDR:
  - mem_req=1. All mem_* outputs come from the latched registers.
  - On mem_addrOK, the granted master's addrOK pulses high in the same cycle.
  - A write goes to IDLE. A read goes to DATA.
- DATA:
  - mem_req=0.
  - On mem_dataOK, the granted master's dataOK pulses high and its rdata equals mem_rdata in the same cycle. The FSM then goes to IDLE.
- Non-granted masters see addrOK=0 and dataOK=0 in every cycle.
- rdata outputs are driven from mem_rdata at all times. They are only meaningful when the matching dataOK is high.
- Requests are sampled only in IDLE.
  - A master must hold req and its fields stable until it sees its addrOK.
  - A req still high in the next IDLE cycle is a new request.
- Ignored inputs: mem_addrOK outside ADDR, mem_dataOK outside DATA.
- Tie-break when both masters request in IDLE: see Configuration. A lone requester always wins.
- Reset values:
  - state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_size=0, mem_wstrb=0.
  - All addrOK/dataOK outputs are 0. grant=dcache. last_grant=icache.

## Timing
- Request to mem_req: 1 cycle. Request seen in IDLE at edge N gives mem_req high from cycle N+1.
- Write: ends in the mem_addrOK cycle. IDLE again 1 cycle later.
- Read: ends in the mem_dataOK cycle. IDLE again 1 cycle later.
- Minimum back-to-back spacing:
  - writes: 2 cycles per transaction;
  - reads: 3 cycles per transaction.
- mem_addrOK and mem_dataOK are both taken as combinational passthroughs to the granted master; neither is registered.
- Reset asserted mid-transaction: at the next edge the FSM is in IDLE and mem_req=0. Any later response from the bridge is ignored. The bridge is reset by the same rst.

## Configuration
- MEM_ARB_RR_EN defined: round-robin tie-break.
  - On a tie, the master not in last_grant wins.
  - last_grant updates on every grant.
  - After reset, the data cache wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority. The data cache always wins a tie, and last_grant is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ADDR/DATA);
  - grant IDs GNT_DCACHE=1'b0 and GNT_ICACHE=1'b1;
  - size constants SIZE_B=0, SIZE_H=1, SIZE_W=2.
- Sub-module mem_arb_grant is combinational: inputs are two requests plus last_grant, output is the winner ID. The MEM_ARB_RR_EN choice is made inside it.

## Test plan
- Dcache read, addr 0x1C000100, bridge addrOK at +2 and dataOK at +3 with rdata=256'hA5… → mem_dcache_addrOK and mem_dcache_dataOK pulse in those same cycles, rdata matches, icache sees no pulses.
- Dcache write, addr 0x1FAF0000, wdata 0x12345678, wstrb 4'b0010, size 0 → mem_* carries exactly these values. Transaction ends on addrOK, no DATA state, IDLE the following cycle.
- Both masters request every cycle for 4 transactions, RR build → grants D, I, D, I. Fixed build → D, D, D, D.
- Icache read alone, addr 0x1C000000 → mem_wr=0, mem_size=2, mem_wstrb=4'hF.
- Spurious mem_dataOK during ADDR and mem_addrOK during DATA → no output pulses, state unchanged.
- rst asserted in DATA → IDLE and mem_req=0 next cycle. A subsequent dataOK produces no pulse.
